// File: rtl/pc_subtractor_serial.sv
// Bit-serial subtractor: diferenca = pc - pc_decrement - BIN (mod 2^WIDTH), BOUT = borrow-out.
// Latency: WIDTH+1 clock edges from the accepting edge to the cycle where done is high.
// Flow: start accepted only while not busy (IDLE or DONE); start during RUN is ignored.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request, accepted when busy=0
//   pc, pc_decrement, BIN  minuend, subtrahend, borrow-in (sampled only on accept)
//   busy                   high exactly while the serial loop runs
//   done                   one-cycle pulse when diferenca/BOUT are fresh
//   diferenca, BOUT        result and borrow-out, held until the next done
module pc_subtractor_serial #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_decrement,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diferenca,
  output logic             BOUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // minuend, shifted right one bit per RUN cycle
  logic [WIDTH-1:0] b_q, b_d;      // subtrahend, shifted alongside
  logic [WIDTH-1:0] res_q, res_d;  // partial result, filled from the MSB side
  logic             br_q, br_d;    // running borrow
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             bout_q, bout_d;

  logic bit_d;
  logic br_nxt;

  // One-bit full subtractor on the current LSBs.
  assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    dif_d   = dif_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = pc;
          b_d     = pc_decrement;
          br_d    = BIN;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Outputs are only written here, so partial results never leak out.
          dif_d   = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      dif_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      dif_q   <= dif_d;
      bout_q  <= bout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign diferenca = dif_q;
  assign BOUT      = bout_q;

endmodule

// File: tb/tb_pc_subtractor_serial.sv
module tb_pc_subtractor_serial;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] pc_decrement = '0;
  logic         BIN = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diferenca;
  logic         BOUT;

  pc_subtractor_serial #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pc           (pc),
    .pc_decrement (pc_decrement),
    .BIN          (BIN),
    .busy         (busy),
    .done         (done),
    .diferenca    (diferenca),
    .BOUT         (BOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dif;
    logic         bout;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] held_dif = '0;
  logic         held_bout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented; otherwise the
  // result outputs must hold the last delivered value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diferenca", diferenca, e.dif);
          chk("BOUT", BOUT, e.bout);
          chk("done_latency_cycle", cyc, e.cyc);
          chk("busy_at_done", busy, 0);
          held_dif  = e.dif;
          held_bout = e.bout;
        end
      end else begin
        chk("hold_diferenca", diferenca, held_dif);
        chk("hold_BOUT", BOUT, held_bout);
      end
    end
  end

  // Drive one request at a negedge; accepting edge follows, done expected 25 edges later.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] ed, input logic eb);
    exp_t e;
    pc = a; pc_decrement = b; BIN = bi; start = 1'b1;
    e.dif = ed; e.bout = eb; e.cyc = cyc + W + 1;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] ed, input logic eb);
    @(negedge clk);
    issue(a, b, bi, ed, eb);
    @(negedge clk);
    start = 1'b0;
    pc = 'x; pc_decrement = 'x; BIN = 1'bx;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{24'h000010, 24'h000001, 1'b0, 24'h00000F, 1'b0};
    vecs[1] = '{24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0};
    vecs[4] = '{24'h800000, 24'h000001, 1'b1, 24'h7FFFFE, 1'b0};
    vecs[5] = '{24'h000005, 24'h000005, 1'b1, 24'hFFFFFF, 1'b1};
    vecs[6] = '{24'h000001, 24'h000000, 1'b1, 24'h000000, 1'b0};
    vecs[7] = '{24'hABCDEF, 24'h123456, 1'b0, 24'h999999, 1'b0};
    vecs[8] = '{24'h123456, 24'hABCDEF, 1'b0, 24'h666667, 1'b1};
    vecs[9] = '{24'h123456, 24'h000456, 1'b0, 24'h123000, 1'b0};

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diferenca", diferenca, 0);
    chk("rst_BOUT", BOUT, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo);
      wait_done();
    end

    // Start re-pulsed during RUN is ignored
    do_op(24'h000010, 24'h000001, 1'b0, 24'h00000F, 1'b0);
    repeat (9) @(negedge clk);
    pc = 24'h777777; pc_decrement = 24'h111111; BIN = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", busy, 1);
    wait_done();
    repeat (3) @(negedge clk);

    // Reset at cycle 12 of RUN aborts, outputs clear without a clock edge
    do_op(24'h00ABCD, 24'h000123, 1'b0, 24'h00AAAA, 1'b0);
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    held_dif  = '0;
    held_bout = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diferenca", diferenca, 0);
    chk("abort_BOUT", BOUT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", done, 0);

    // Fresh start after reset completes normally
    do_op(24'h00ABCD, 24'h000123, 1'b0, 24'h00AAAA, 1'b0);
    wait_done();

    // Back-to-back: start held through DONE
    do_op(24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1);
    pc = 24'h123456; pc_decrement = 24'h000456; BIN = 1'b0; start = 1'b1;
    wait_done();
    begin
      exp_t e;
      e.dif = 24'h123000; e.bout = 1'b0; e.cyc = cyc + W + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_back_to_back", busy, 1);
    @(negedge clk);
    wait_done();
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
